seg_display_arbiter: RTL and testbench

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_arb_pkg.sv | 42 ++++
 rtl/hex_to_seg.sv | 11 +
 rtl/seg_display_arbiter.sv | 159 +++++++++++++++
 tb/tb_seg_display_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the 7-segment display arbiter: FSM states,
// requester count, active-low hex glyph table and the round-robin picker.
package seg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int NUM_REQ = 3;
  localparam int PTR_W   = $clog2(NUM_REQ);

  typedef logic [PTR_W-1:0] req_idx_t;

  // Active-low segment patterns, bit order g..a, for nibbles 0-F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // First set requester strictly after ptr in cyclic order; ptr itself is
  // checked last, so a lone current owner is found only when nobody else asks.
  function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input req_idx_t           ptr);
    req_idx_t pick;
    req_idx_t cand;
    logic     found;
    int       tmp;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      tmp  = (int'(ptr) + i) % NUM_REQ;
      cand = req_idx_t'(tmp);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph (g..a).
module hex_to_seg
  import seg_arb_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH[nibble_i];

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter granting a 4-digit multiplexed 7-segment display to one
// of three requesters; ownership changes only on frame boundaries.
// Optional macro SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [15:0]        data0,
  input  logic [15:0]        data1,
  input  logic [15:0]        data2,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic [3:0]         an,
  output logic [7:0]         seg
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam req_idx_t          PTR_RST  = req_idx_t'(NUM_REQ - 1);

  logic [DIV_W-1:0]   div_q;
  logic [1:0]         idx_q;
  logic               tick;
  logic               frame_end;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  req_idx_t           ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [15:0]        word_q, word_d;

  logic [HOLD_W-1:0]  hold_inc;
  logic [NUM_REQ-1:0] others;
  req_idx_t           pick;
  logic               owner_req;
  logic [3:0]         nibble;
  logic [6:0]         glyph;
  logic               blank;

  function automatic logic [15:0] data_sel(input req_idx_t i);
    case (i)
      req_idx_t'(0): data_sel = data0;
      req_idx_t'(1): data_sel = data1;
      default:       data_sel = data2;
    endcase
  endfunction

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (idx_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      word_q  <= word_d;
    end
  end

  // While owned, ptr_q is the owner index, so it doubles as the owner select.
  assign owner_req = req[ptr_q];
  assign others    = req & ~grant_q;
  assign pick      = rr_pick(req, ptr_q);
  assign hold_inc  = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

  // NOTE: every next-state signal gets a default first so no path through
  // this block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    word_d  = word_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_d = OWN;
            grant_d = NUM_REQ'(1) << pick;
            ptr_d   = pick;
            hold_d  = '0;
            word_d  = data_sel(pick);
          end
        end
        OWN: begin
          hold_d = hold_inc;
          if (owner_req) word_d = data_sel(ptr_q);
          if (hold_inc == HOLD_MAX) begin
            if (|others) begin
              grant_d = NUM_REQ'(1) << pick;
              ptr_d   = pick;
              hold_d  = '0;
              word_d  = data_sel(pick);
            end else if (!owner_req) begin
              state_d = IDLE;
              grant_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign nibble = 4'(word_q >> {idx_q, 2'b00});

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

`ifdef SEG_BLANK_LEADING_ZERO_EN
  // A digit is a leading zero when it and everything above it are zero.
  assign blank = (idx_q != 2'd0) && ((word_q >> {idx_q, 2'b00}) == 16'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an  = 4'hF;
    seg = 8'hFF;
    if (state_q == OWN) begin
      an = ~(4'b0001 << idx_q);
      if (!blank) seg = {1'b1, glyph};
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed phases plus random
// requests, compared every cycle against a cycle-count based reference model.
module tb_seg_display_arbiter;

  localparam int SCAN_DIV    = 4;
  localparam int HOLD_FRAMES = 2;
  localparam int FRAME_CLKS  = 4 * SCAN_DIV;

  // Active-high segment patterns (g..a) for 0-F; the DUT drives the inverse.
  localparam logic [6:0] SEG_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  grant;
  logic        busy;
  logic [3:0]  an;
  logic [7:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_owner;
  int          m_ptr;
  int          m_held;
  int          m_cyc;
  logic [15:0] m_word;

  always #5 clk = ~clk;

  seg_display_arbiter #(
    .SCAN_DIV    (SCAN_DIV),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .data0 (data0),
    .data1 (data1),
    .data2 (data2),
    .grant (grant),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] data_of(input int r);
    if (r == 0) return data0;
    if (r == 1) return data1;
    return data2;
  endfunction

  function automatic int rr_next(input logic [2:0] r, input int from);
    for (int i = 1; i <= 3; i++) begin
      if (r[(from + i) % 3]) return (from + i) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 2;
    m_held  = 0;
    m_word  = '0;
    m_cyc   = 0;
  endtask

  // Cycle m_cyc (counted from reset release) closes a frame when it is the
  // last clock of a 16-clock frame.
  task automatic model_edge();
    logic [2:0] others;
    if (m_cyc % FRAME_CLKS == FRAME_CLKS - 1) begin
      if (m_owner < 0) begin
        if (req != 3'b000) begin
          m_owner = rr_next(req, m_ptr);
          m_ptr   = m_owner;
          m_held  = 0;
          m_word  = data_of(m_owner);
        end
      end else begin
        m_held = (m_held < HOLD_FRAMES) ? m_held + 1 : HOLD_FRAMES;
        others = req & ~(3'b001 << m_owner);
        if (m_held == HOLD_FRAMES && others != 3'b000) begin
          m_owner = rr_next(others, m_owner);
          m_ptr   = m_owner;
          m_held  = 0;
          m_word  = data_of(m_owner);
        end else if (m_held == HOLD_FRAMES && !req[m_owner]) begin
          m_owner = -1;
        end else if (req[m_owner]) begin
          m_word = data_of(m_owner);
        end
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs(input string tag);
    int          idx;
    logic [3:0]  nib;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic [2:0]  exp_grant;
    logic        blank;
    idx       = (m_cyc / SCAN_DIV) % 4;
    exp_an    = 4'hF;
    exp_seg   = 8'hFF;
    exp_grant = 3'b000;
    if (m_owner >= 0) begin
      exp_grant   = 3'b000;
      exp_grant[m_owner] = 1'b1;
      exp_an[idx] = 1'b0;
      nib         = m_word[idx*4 +: 4];
      blank       = 1'b0;
`ifdef SEG_BLANK_LEADING_ZERO_EN
      blank = (idx > 0) && ((m_word >> (4 * idx)) == 16'd0);
`endif
      if (!blank) exp_seg = {1'b1, ~SEG_ON[nib]};
    end
    check($sformatf("%s.grant", tag), 32'(grant), 32'(exp_grant));
    check($sformatf("%s.busy", tag),  32'(busy),  32'(exp_grant != 3'b000));
    check($sformatf("%s.an", tag),    32'(an),    32'(exp_an));
    check($sformatf("%s.seg", tag),   32'(seg),   32'(exp_seg));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    reset = 1'b0;
    req   = 3'b000;
    data0 = '0;
    data1 = '0;
    data2 = '0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Idle with no requests.
    run(40, "idle");

    // Single requester: glyphs B,A,2,1 on an E,D,B,7.
    req   = 3'b001;
    data0 = 16'h12AB;
    run(64, "single");

    // All requesting: rotation 0,1,2,0 with two-frame holds.
    req   = 3'b111;
    data1 = 16'h3C4D;
    data2 = 16'hE5F6;
    run(130, "rotate");

    // Owner 0 drops its request one frame after the grant.
    req = 3'b000;
    run(64, "drain");
    req   = 3'b001;
    data0 = 16'($urandom);
    for (int i = 0; i < 64 && m_owner != 0; i++) step("wait_grant");
    check("drop.granted", 32'(grant), 32'(3'b001));
    run(FRAME_CLKS, "drop_hold");
    req = 3'b000;
    data0 = 16'($urandom);
    run(48, "drop_freeze");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        data0 = 16'($urandom);
        data1 = 16'($urandom);
        data2 = 16'($urandom);
      end
      step("random");
    end

    // Asynchronous reset in the middle of a digit while owned.
    req = 3'b100;
    for (int i = 0; i < 64 && m_owner < 0; i++) step("wait_own");
    check("pre_reset.busy", 32'(busy), 32'(1'b1));
    run(5, "pre_reset");
    #1;
    reset = 1'b0;
    #1;
    check("async_rst.an",    32'(an),    32'(4'hF));
    check("async_rst.seg",   32'(seg),   32'(8'hFF));
    check("async_rst.grant", 32'(grant), 32'(3'b000));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 3'b010;
    run(FRAME_CLKS, "post_reset");
    check("post_reset.first_grant", 32'(grant), 32'(3'b010));
    run(24, "post_reset");

    // Leading-zero patterns.
    req   = 3'b001;
    data0 = 16'h0005;
    run(80, "lz_0005");
    data0 = 16'h0000;
    run(48, "lz_0000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
